enc_sched: RTL

//  Shares one Encrypt core among NREQ requesters using round-robin arbitration.

---
 rtl/enc_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/enc_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the encrypt-core scheduler: FSM encoding, default
// word width and the bus-slice helper used to pick one requester's operand.
package enc_pkg;

  localparam int W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Low bit of slot idx in a bus of equal-width words packed from bit 0 upward.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first set request bit
// found searching upward from the slot after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  // Rotating priority search; the last-served slot is checked last.
  always_comb begin
    int   cand;
    logic found;
    win     = {NREQ{1'b0}};
    win_idx = {IW{1'b0}};
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        win[cand]    = 1'b1;
        win_idx      = IW'(cand);
      end else begin
        found = found;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/enc_sched.sv
// Shares one Encrypt core among NREQ requesters: arbitrates, loads operands,
// pulses the core reset, waits for completion or timeout, returns a response.
module enc_sched
  import enc_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = W_DEF,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       req_pt,
  input  logic [NREQ*W-1:0]       req_nonce,
  input  logic [W-1:0]            key,
  input  logic [W-1:0]            s,
  input  logic [W-1:0]            a,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_ct,
  output logic                    rsp_tag,
  output logic                    rsp_err,
  output logic                    enc_rst,
  output logic [W-1:0]            enc_k,
  output logic [W-1:0]            enc_s,
  output logic [W-1:0]            enc_a,
  output logic [W-1:0]            enc_nonce,
  output logic [W-1:0]            enc_p,
  input  logic [W-1:0]            enc_c,
  input  logic                    enc_tag,
  input  logic                    enc_done
);

  localparam int IW  = $clog2(NREQ);
  localparam int LCW = $clog2(RST_CYC) + 1;
  localparam int TCW = $clog2(TIMEOUT);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(RST_CYC - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  state_t            state_r, state_s;
  logic [IW-1:0]     ptr_r;
  logic [LCW-1:0]    lcnt_r;
  logic [TCW-1:0]    tcnt_r;

  logic [NREQ-1:0]   win_s;
  logic [IW-1:0]     win_idx_s;
  logic              any_s;
  logic              done_hit_s, tmo_s;
  logic [NREQ-1:0]   gnt_s;
  logic              busy_s, valid_s, enc_rst_s;
  logic              load_s, cap_done_s, cap_tmo_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr_r),
    .win     (win_s),
    .win_idx (win_idx_s),
    .any     (any_s)
  );

  // A done level in the first RUN cycle may be left over from the previous run.
  assign done_hit_s = enc_done && (tcnt_r != {TCW{1'b0}});
  assign tmo_s      = (tcnt_r == TMO_LAST) && !done_hit_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (lcnt_r == LOAD_LAST) state_s = ST_RUN;
        else                     state_s = ST_LOAD;
      end
      ST_RUN: begin
        if (done_hit_s || tmo_s) state_s = ST_RESP;
        else                     state_s = ST_RUN;
      end
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else           state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and capture strobes.
  always_comb begin
    gnt_s      = (state_r == ST_IDLE) ? win_s : {NREQ{1'b0}};
    busy_s     = (state_s != ST_IDLE);
    valid_s    = (state_s == ST_RESP);
    enc_rst_s  = (state_s != ST_RUN);
    load_s     = (state_r == ST_IDLE) && any_s;
    cap_done_s = (state_r == ST_RUN) && done_hit_s;
    cap_tmo_s  = (state_r == ST_RUN) && tmo_s;
  end

  // LOAD length counter and saturating RUN timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt_r <= {LCW{1'b0}};
      tcnt_r <= {TCW{1'b0}};
    end else begin
      lcnt_r <= (state_r == ST_LOAD) ? lcnt_r + LCW'(1) : {LCW{1'b0}};
      if (state_r != ST_RUN)    tcnt_r <= {TCW{1'b0}};
      else if (tcnt_r != TMO_LAST) tcnt_r <= tcnt_r + TCW'(1);
      else                      tcnt_r <= tcnt_r;
    end
  end

  // Registered outputs, operand latches, response capture and arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= {NREQ{1'b0}};
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      enc_rst   <= 1'b1;
      rsp_id    <= {IW{1'b0}};
      rsp_ct    <= {W{1'b0}};
      rsp_tag   <= 1'b0;
      rsp_err   <= 1'b0;
      enc_k     <= {W{1'b0}};
      enc_s     <= {W{1'b0}};
      enc_a     <= {W{1'b0}};
      enc_nonce <= {W{1'b0}};
      enc_p     <= {W{1'b0}};
      ptr_r     <= IW'(NREQ - 1);
    end else begin
      gnt       <= gnt_s;
      busy      <= busy_s;
      rsp_valid <= valid_s;
      enc_rst   <= enc_rst_s;
      if (load_s) begin
        enc_k     <= key;
        enc_s     <= s;
        enc_a     <= a;
        enc_p     <= req_pt[slice_lo(int'(win_idx_s), W) +: W];
        enc_nonce <= req_nonce[slice_lo(int'(win_idx_s), W) +: W];
        rsp_id    <= win_idx_s;
        ptr_r     <= win_idx_s;
      end
      if (cap_done_s) begin
        rsp_ct  <= enc_c;
        rsp_tag <= enc_tag;
        rsp_err <= 1'b0;
      end else if (cap_tmo_s) begin
        rsp_ct  <= {W{1'b0}};
        rsp_tag <= 1'b0;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule
